scanline_fetcher: RTL and testbench
===================================

Name: scanline_fetcher

Overview:
- Fills the 256-entry scanline memory during horizontal blanking, one line ahead of display.
- For each of the 64 block columns, reads the tile-map word, the 12-pixel pattern row and (per column pair) the 4-colour palette from main memory.
- Writes them in the layout the video generator consumes: colours at 0x00-0x7F, pattern rows at 0x80-0xBF.
- Sits between main memory (14-bit address, 12-bit data) and the write port of the scanline memory.
- Driven by a start pulse from the video timing logic.

Parameters:
- MAP_BASE, 14'h0000: base of the 64x64 tile map, word index {y_block, col}.
- PAT_BASE, 14'h1000: base of the pattern table, 12 words per tile, one per pixel row.
- PAL_BASE, 14'h1C00: base of the palette table, 16 palettes x 4 colours, index {pal, k}.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  single-cycle request to fetch one line
- y_block  in  6  block row of the line to fetch
- y_pixel  in  4  pixel row within the block, 0..11
- x_block_start  in  6  first displayed block column (scroll)
- mem_addr  out  14  main memory read address
- mem_data  in  12  read data; valid the cycle after mem_addr is presented
- vmem_addr  out  8  scanline memory write address
- vmem_data  out  12  scanline memory write data
- vmem_wren  out  1  scanline memory write enable
- busy  out  1  fetch in progress
- done  out  1  single-cycle pulse on the final write

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - busy=0, done=0, vmem_wren=0, vmem_addr=0, pair counter=0.
  - State goes to IDLE.
  - mem_addr=MAP_BASE.
  - Reset mid-fetch abandons the line; writes already made stay in memory.
- IDLE:
  - start=1 latches y_block, y_pixel and x_block_start, clears pair counter p (0..31), enters MAP0.
  - start while busy is ignored.
  - busy=1 from the cycle after start until the end of the DRAIN cycle.
- Per column pair, 8 cycles, column c=2p. col(n)=(x_block_start+n) mod 64.
  - MAP0: mem_addr = MAP_BASE+{y_block,col(c)}.
  - MAP1: mem_addr = MAP_BASE+{y_block,col(c+1)}; capture mem_data into map_e.
  - PAT0: mem_addr = PAT_BASE + map_e[7:0]*12 + y_pixel; capture mem_data into map_o.
  - PAT1: mem_addr = PAT_BASE + map_o[7:0]*12 + y_pixel.
  - PAL0..PAL3 (k=0..3): mem_addr = PAL_BASE+{map_e[11:8],k}. The odd column's palette bits are unused.
  - After PAL3: p increments. p=31 goes to DRAIN, otherwise MAP0.
- Map word format: [7:0] tile index, [11:8] palette number.
- Address arithmetic is 14-bit, modulo 2^14. tile*12 is formed as (tile<<3)+(tile<<2).
- Writes (vmem_addr/vmem_wren registered, vmem_data = mem_data combinationally). A read issued in cycle t is written in cycle t+1:
  - pattern for c -> 0x80+c
  - pattern for c+1 -> 0x81+c
  - palette colour k -> {1'b0, p[4:0], k[1:0]}
- Map reads never write; vmem_wren=0 in the cycles following MAP0/MAP1 reads. PAL3's write lands in the next pair's MAP0 cycle, or in DRAIN for p=31.
- Totals: 256 issue cycles + 1 DRAIN = 257 cycles after start; 192 writes per line.
- DRAIN: done=1, last write performed, then back to IDLE with busy=0.
- The whole fetch fits inside the 304-cycle blanking window (vga_x 992..1023, 0..271). The start pulse is issued at vga_x=992.
- The display read port is idle for the whole window, so no arbitration is needed.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, MAP0, MAP1, PAT0, PAT1, PAL0-3, DRAIN
  - map-word field positions
  - scanline memory region bases: 8'h00 colours, 8'h80 patterns
  - the constants 12 (pixels per block) and 64 (columns)
- One natural sub-module: fetch_addr_gen. It is combinational: state, counters, latched line parameters and map_e/map_o in; mem_addr out.

Test Plan:
- Reset, then start with y_block=3, y_pixel=5, x_block_start=0.
  - Map word at 0x00C0 is 0x20A.
  - Requires the first mem_addr sequence 0x00C0, 0x00C1, then 0x1000+0x0A*12+5=0x107D.
  - Pattern write at 0x80.
  - Palette reads 0x1C08..0x1C0B written to 0x00..0x03.
- Scroll wrap: x_block_start=63.
  - Requires col(0)=63 (MAP addr {y_block,63}) and col(1)=0.
  - Pattern writes still land at 0x80 and 0x81.
- Full line:
  - Count exactly 192 vmem_wren cycles.
  - done high exactly 257 cycles after start; busy deasserts the next cycle.
  - Final write address is 0x7F.
- Address wrap: tile index 0xFF, y_pixel=11.
  - Pattern address = 0x1000+3060+11 = 0x1BFF.
- start pulsed again at cycle 100 of a fetch -> ignored: write sequence and done timing unchanged.
- rst asserted at cycle 50 -> next cycle busy=0, vmem_wren=0, no done.
  - A new start then runs a full 257-cycle fetch.

Source files
------------

// File: rtl/scanline_fetcher_pkg.sv
// Shared state encoding, map-word layout and scanline-memory layout constants
// for the scanline fetcher and its address generator.
package scanline_fetcher_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_MAP0  = 4'd1,
        ST_MAP1  = 4'd2,
        ST_PAT0  = 4'd3,
        ST_PAT1  = 4'd4,
        ST_PAL0  = 4'd5,
        ST_PAL1  = 4'd6,
        ST_PAL2  = 4'd7,
        ST_PAL3  = 4'd8,
        ST_DRAIN = 4'd9
    } fetch_state_t;

    localparam int MAP_TILE_LSB = 0;
    localparam int MAP_TILE_MSB = 7;
    localparam int MAP_PAL_LSB  = 8;
    localparam int MAP_PAL_MSB  = 11;

    localparam logic [7:0] VMEM_COLOUR_BASE  = 8'h00;
    localparam logic [7:0] VMEM_PATTERN_BASE = 8'h80;

    localparam int PIXELS_PER_BLOCK = 12;
    localparam int NUM_COLUMNS      = 64;
    localparam logic [4:0] LAST_PAIR = 5'(NUM_COLUMNS / 2 - 1);

    // tile * PIXELS_PER_BLOCK built from two shifts so no multiplier is inferred
    function automatic logic [13:0] tile_row_offset(input logic [7:0] tile);
        logic [13:0] t;
        t = {6'd0, tile};
        return (t << 3) + (t << 2);
    endfunction

endpackage

// File: rtl/scanline_fetcher_fetch_addr_gen.sv
// Combinational main-memory read address for each step of a column-pair fetch.
module fetch_addr_gen
    import scanline_fetcher_pkg::*;
#(
    parameter logic [13:0] MAP_BASE = 14'h0000,
    parameter logic [13:0] PAT_BASE = 14'h1000,
    parameter logic [13:0] PAL_BASE = 14'h1C00
) (
    input  fetch_state_t state,
    input  logic [4:0]   pair,
    input  logic [5:0]   y_block,
    input  logic [3:0]   y_pixel,
    input  logic [5:0]   x_block_start,
    input  logic [11:0]  map_e,
    input  logic [7:0]   map_o_tile,
    output logic [13:0]  mem_addr
);

    logic [5:0]  col_even_s;
    logic [5:0]  col_odd_s;
    logic [13:0] pat_row_s;

    // Column indices wrap naturally in 6 bits, giving the scroll wrap-around
    assign col_even_s = x_block_start + {pair, 1'b0};
    assign col_odd_s  = col_even_s + 6'd1;
    assign pat_row_s  = {10'd0, y_pixel};

    // Read address selection per fetch step; idle/drain park on the map base
    always_comb begin
        mem_addr = MAP_BASE;
        case (state)
            ST_MAP0: mem_addr = MAP_BASE + {2'b00, y_block, col_even_s};
            ST_MAP1: mem_addr = MAP_BASE + {2'b00, y_block, col_odd_s};
            ST_PAT0: mem_addr = PAT_BASE + tile_row_offset(map_e[MAP_TILE_MSB:MAP_TILE_LSB]) + pat_row_s;
            ST_PAT1: mem_addr = PAT_BASE + tile_row_offset(map_o_tile) + pat_row_s;
            ST_PAL0: mem_addr = PAL_BASE + {8'd0, map_e[MAP_PAL_MSB:MAP_PAL_LSB], 2'd0};
            ST_PAL1: mem_addr = PAL_BASE + {8'd0, map_e[MAP_PAL_MSB:MAP_PAL_LSB], 2'd1};
            ST_PAL2: mem_addr = PAL_BASE + {8'd0, map_e[MAP_PAL_MSB:MAP_PAL_LSB], 2'd2};
            ST_PAL3: mem_addr = PAL_BASE + {8'd0, map_e[MAP_PAL_MSB:MAP_PAL_LSB], 2'd3};
            default: mem_addr = MAP_BASE;
        endcase
    end

endmodule

// File: rtl/scanline_fetcher.sv
// Fetches one line of tile-map, pattern and palette data from main memory into
// the scanline memory, one column pair every eight cycles.
module scanline_fetcher
    import scanline_fetcher_pkg::*;
#(
    parameter logic [13:0] MAP_BASE = 14'h0000,
    parameter logic [13:0] PAT_BASE = 14'h1000,
    parameter logic [13:0] PAL_BASE = 14'h1C00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  y_block,
    input  logic [3:0]  y_pixel,
    input  logic [5:0]  x_block_start,
    output logic [13:0] mem_addr,
    input  logic [11:0] mem_data,
    output logic [7:0]  vmem_addr,
    output logic [11:0] vmem_data,
    output logic        vmem_wren,
    output logic        busy,
    output logic        done
);

    fetch_state_t state_r;
    fetch_state_t next_state_s;
    logic [4:0]   pair_r;
    logic [5:0]   y_block_r;
    logic [3:0]   y_pixel_r;
    logic [5:0]   x_start_r;
    logic [11:0]  map_e_r;
    logic [7:0]   map_o_r;
    logic         wr_en_s;
    logic [7:0]   wr_addr_s;

    fetch_addr_gen #(
        .MAP_BASE (MAP_BASE),
        .PAT_BASE (PAT_BASE),
        .PAL_BASE (PAL_BASE)
    ) u_addr_gen (
        .state         (state_r),
        .pair          (pair_r),
        .y_block       (y_block_r),
        .y_pixel       (y_pixel_r),
        .x_block_start (x_start_r),
        .map_e         (map_e_r),
        .map_o_tile    (map_o_r),
        .mem_addr      (mem_addr)
    );

    // Read data arrives one cycle after its address, so it is written straight through
    assign vmem_data = mem_data;

    // Fetch state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state sequencing through the eight steps of each column pair
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_MAP0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MAP0: next_state_s = ST_MAP1;
            ST_MAP1: next_state_s = ST_PAT0;
            ST_PAT0: next_state_s = ST_PAT1;
            ST_PAT1: next_state_s = ST_PAL0;
            ST_PAL0: next_state_s = ST_PAL1;
            ST_PAL1: next_state_s = ST_PAL2;
            ST_PAL2: next_state_s = ST_PAL3;
            ST_PAL3: begin
                if (pair_r == LAST_PAIR) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_MAP0;
                end
            end
            ST_DRAIN: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Destination of the read issued this cycle; map reads produce no write
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = VMEM_COLOUR_BASE;
        case (state_r)
            ST_PAT0: begin
                wr_en_s   = 1'b1;
                wr_addr_s = VMEM_PATTERN_BASE + {2'b00, pair_r, 1'b0};
            end
            ST_PAT1: begin
                wr_en_s   = 1'b1;
                wr_addr_s = VMEM_PATTERN_BASE + {2'b00, pair_r, 1'b1};
            end
            ST_PAL0: begin
                wr_en_s   = 1'b1;
                wr_addr_s = VMEM_COLOUR_BASE + {1'b0, pair_r, 2'd0};
            end
            ST_PAL1: begin
                wr_en_s   = 1'b1;
                wr_addr_s = VMEM_COLOUR_BASE + {1'b0, pair_r, 2'd1};
            end
            ST_PAL2: begin
                wr_en_s   = 1'b1;
                wr_addr_s = VMEM_COLOUR_BASE + {1'b0, pair_r, 2'd2};
            end
            ST_PAL3: begin
                wr_en_s   = 1'b1;
                wr_addr_s = VMEM_COLOUR_BASE + {1'b0, pair_r, 2'd3};
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_addr_s = VMEM_COLOUR_BASE;
            end
        endcase
    end

    // Line parameters, pair counter and captured map words
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_r    <= 5'd0;
            y_block_r <= 6'd0;
            y_pixel_r <= 4'd0;
            x_start_r <= 6'd0;
            map_e_r   <= 12'd0;
            map_o_r   <= 8'd0;
        end else begin
            if ((state_r == ST_IDLE) && start) begin
                y_block_r <= y_block;
                y_pixel_r <= y_pixel;
                x_start_r <= x_block_start;
                pair_r    <= 5'd0;
            end else if (state_r == ST_PAL3) begin
                pair_r <= pair_r + 5'd1;
            end
            if (state_r == ST_MAP1) begin
                map_e_r <= mem_data;
            end
            if (state_r == ST_PAT0) begin
                map_o_r <= mem_data[MAP_TILE_MSB:MAP_TILE_LSB];
            end
        end
    end

    // Registered write strobe, write address and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            vmem_wren <= 1'b0;
            vmem_addr <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            vmem_wren <= wr_en_s;
            if (wr_en_s) begin
                vmem_addr <= wr_addr_s;
            end
            busy <= (next_state_s != ST_IDLE);
            done <= (next_state_s == ST_DRAIN);
        end
    end

endmodule

// File: tb/tb_scanline_fetcher.sv
// Self-checking bench: registered main-memory model plus a scoreboard of the
// expected scanline-memory writes for each requested line.
module tb_scanline_fetcher;

    localparam logic [13:0] MAP_BASE = 14'h0000;
    localparam logic [13:0] PAT_BASE = 14'h1000;
    localparam logic [13:0] PAL_BASE = 14'h1C00;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  y_block;
    logic [3:0]  y_pixel;
    logic [5:0]  x_block_start;
    logic [13:0] mem_addr;
    logic [11:0] mem_data;
    logic [7:0]  vmem_addr;
    logic [11:0] vmem_data;
    logic        vmem_wren;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] mem [0:16383];
    logic [19:0] exp_q [$];
    logic [13:0] addr_trace [0:300];
    logic [7:0]  wr_log [0:191];
    int          wr_count;
    int          done_cycle;
    int          done_pulses;
    int          busy_low_cycle;
    logic        rst_busy;
    logic        rst_wren;
    logic        rst_done;
    logic [13:0] rst_mem_addr;

    scanline_fetcher dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .y_block       (y_block),
        .y_pixel       (y_pixel),
        .x_block_start (x_block_start),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .vmem_addr     (vmem_addr),
        .vmem_data     (vmem_data),
        .vmem_wren     (vmem_wren),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Main memory: data for an address appears in the following cycle
    always @(posedge clk) mem_data <= mem[mem_addr];

    task automatic build_expected(input logic [5:0] yb, input logic [3:0] yp, input logic [5:0] xs);
        int ce, co, me, mo, pe, po;
        for (int p = 0; p < 32; p++) begin
            ce = (int'(xs) + 2 * p) % 64;
            co = (int'(xs) + 2 * p + 1) % 64;
            me = int'(mem[int'(MAP_BASE) + int'(yb) * 64 + ce]);
            mo = int'(mem[int'(MAP_BASE) + int'(yb) * 64 + co]);
            pe = (int'(PAT_BASE) + (me % 256) * 12 + int'(yp)) % 16384;
            po = (int'(PAT_BASE) + (mo % 256) * 12 + int'(yp)) % 16384;
            exp_q.push_back({8'(128 + 2 * p), mem[pe]});
            exp_q.push_back({8'(129 + 2 * p), mem[po]});
            for (int k = 0; k < 4; k++)
                exp_q.push_back({8'(4 * p + k), mem[int'(PAL_BASE) + (me / 256) * 4 + k]});
        end
    endtask

    // Drives one start request and follows the line, comparing every write against the scoreboard
    task automatic fetch_line(input logic [5:0] yb, input logic [3:0] yp, input logic [5:0] xs,
                              input int restart_at, input int rst_at);
        logic [19:0] e;
        bit finished;
        finished = 1'b0;
        wr_count = 0;
        done_cycle = -1;
        done_pulses = 0;
        busy_low_cycle = -1;
        @(negedge clk);
        y_block = yb;
        y_pixel = yp;
        x_block_start = xs;
        start = 1'b1;
        build_expected(yb, yp, xs);
        for (int k = 1; k <= 300 && !finished; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            addr_trace[k] = mem_addr;
            if (vmem_wren) begin
                if (wr_count < 192) wr_log[wr_count] = vmem_addr;
                wr_count++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_write: cycle %0d addr %h data %h, required no write", k, vmem_addr, vmem_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({vmem_addr, vmem_data} !== e) begin
                        n_fail++;
                        $display("FAIL write_%0d: got addr %h data %h, required addr %h data %h",
                                 wr_count - 1, vmem_addr, vmem_data, e[19:12], e[11:0]);
                    end
                end
            end
            if (done) begin
                done_pulses++;
                if (done_cycle < 0) done_cycle = k;
            end
            if (!busy && busy_low_cycle < 0) busy_low_cycle = k;
            if (k == rst_at + 1 && rst_at > 0) begin
                rst_busy = busy;
                rst_wren = vmem_wren;
                rst_done = done;
                rst_mem_addr = mem_addr;
                rst = 1'b0;
            end
            if (k == rst_at) rst = 1'b1;
            if (rst_at > 0 && k >= rst_at + 4) finished = 1'b1;
            if (rst_at <= 0 && busy_low_cycle > 0 && k > busy_low_cycle) finished = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        y_block = 6'd0;
        y_pixel = 4'd0;
        x_block_start = 6'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, vmem_wren} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/wren %b, required 000", {busy, done, vmem_wren});
        end
        n_checks++;
        if (vmem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_vmem_addr: got %h, required 00", vmem_addr);
        end
        n_checks++;
        if (mem_addr !== MAP_BASE) begin
            n_fail++;
            $display("FAIL reset_mem_addr: got %h, required %h", mem_addr, MAP_BASE);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_pair();
        fetch_line(6'd3, 4'd5, 6'd0, -1, -1);
        n_checks++;
        if (addr_trace[1] !== 14'h00C0 || addr_trace[2] !== 14'h00C1 || addr_trace[3] !== 14'h107D) begin
            n_fail++;
            $display("FAIL first_addrs: got %h %h %h, required 00c0 00c1 107d", addr_trace[1], addr_trace[2], addr_trace[3]);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (addr_trace[5 + i] !== 14'h1C08 + 14'(i)) begin
                n_fail++;
                $display("FAIL pal_read_%0d: got %h, required %h", i, addr_trace[5 + i], 14'h1C08 + 14'(i));
            end
            n_checks++;
            if (wr_log[2 + i] !== 8'(i)) begin
                n_fail++;
                $display("FAIL pal_write_%0d: got %h, required %h", i, wr_log[2 + i], 8'(i));
            end
        end
        n_checks++;
        if (wr_log[0] !== 8'h80) begin
            n_fail++;
            $display("FAIL first_pattern_write: got %h, required 80", wr_log[0]);
        end
    endtask

    task automatic test_scroll_wrap();
        fetch_line(6'd3, 4'd5, 6'd63, -1, -1);
        n_checks++;
        if (addr_trace[1] !== 14'h00FF || addr_trace[2] !== 14'h00C0) begin
            n_fail++;
            $display("FAIL scroll_map_addrs: got %h %h, required 00ff 00c0", addr_trace[1], addr_trace[2]);
        end
        n_checks++;
        if (wr_log[0] !== 8'h80 || wr_log[1] !== 8'h81) begin
            n_fail++;
            $display("FAIL scroll_pattern_writes: got %h %h, required 80 81", wr_log[0], wr_log[1]);
        end
    endtask

    task automatic test_full_line();
        fetch_line(6'd17, 4'd2, 6'd20, -1, -1);
        n_checks++;
        if (wr_count != 192) begin
            n_fail++;
            $display("FAIL full_write_count: got %0d, required 192", wr_count);
        end
        n_checks++;
        if (done_cycle != 257 || done_pulses != 1) begin
            n_fail++;
            $display("FAIL full_done: cycle %0d pulses %0d, required cycle 257 pulses 1", done_cycle, done_pulses);
        end
        n_checks++;
        if (busy_low_cycle != 258) begin
            n_fail++;
            $display("FAIL full_busy_drop: cycle %0d, required 258", busy_low_cycle);
        end
        n_checks++;
        if (wr_log[191] !== 8'h7F) begin
            n_fail++;
            $display("FAIL full_last_addr: got %h, required 7f", wr_log[191]);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_missing_writes: %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_addr_wrap();
        mem[int'(MAP_BASE) + 5 * 64] = 12'h3FF;
        fetch_line(6'd5, 4'd11, 6'd0, -1, -1);
        n_checks++;
        if (addr_trace[3] !== 14'h1BFF) begin
            n_fail++;
            $display("FAIL addr_wrap_pattern: got %h, required 1bff", addr_trace[3]);
        end
    endtask

    task automatic test_back_to_back_start();
        fetch_line(6'd9, 4'd7, 6'd30, 100, -1);
        n_checks++;
        if (wr_count != 192 || done_cycle != 257 || done_pulses != 1 || busy_low_cycle != 258) begin
            n_fail++;
            $display("FAIL restart_ignored: writes %0d done %0d pulses %0d busy_low %0d, required 192 257 1 258",
                     wr_count, done_cycle, done_pulses, busy_low_cycle);
        end
    endtask

    task automatic test_reset_mid_fetch();
        fetch_line(6'd12, 4'd3, 6'd5, -1, 50);
        exp_q.delete();
        n_checks++;
        if ({rst_busy, rst_wren, rst_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_flags: busy/wren/done %b, required 000", {rst_busy, rst_wren, rst_done});
        end
        n_checks++;
        if (done_pulses != 0 || rst_mem_addr !== MAP_BASE) begin
            n_fail++;
            $display("FAIL midreset_idle: done pulses %0d mem_addr %h, required 0 and %h", done_pulses, rst_mem_addr, MAP_BASE);
        end
        fetch_line(6'd12, 4'd3, 6'd5, -1, -1);
        n_checks++;
        if (done_cycle != 257 || wr_count != 192) begin
            n_fail++;
            $display("FAIL midreset_refetch: done %0d writes %0d, required 257 192", done_cycle, wr_count);
        end
    endtask

    // Scenario sequence
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 12'((i * 37 + 11) ^ (i >> 5));
        mem[int'(MAP_BASE) + 14'h00C0] = 12'h20A;
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_first_pair();
        test_scroll_wrap();
        test_full_line();
        test_addr_wrap();
        test_back_to_back_start();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
